// File: rtl/clkdiv_meas.sv
// clkdiv_meas: measures the period of a divided clock in clk_i cycles
// and decodes it back to the power-of-two divider select code.
module clkdiv_meas #(
  parameter int CNT_W    = 18,
  parameter int TIMEOUT  = 131071,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             dclk_i,
  output logic [CNT_W-1:0] period_o,
  output logic [2:0]       sel_o,
  output logic             valid_o,
  output logic             match_o,
  output logic             lock_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] period_n;
  logic [CNT_W-1:0] plen;
  logic [2:0]       sel_n;
  logic [2:0]       code;
  logic [3:0]       mcnt;
  logic [3:0]       mcnt_n;
  logic             valid_n;
  logic             match_n;
  logic             lock_n;
  logic             tmo_n;
  logic             hit;
  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             rise;

  assign rise = sync2 & ~hist;
  assign plen = cnt + CNT_ONE;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= dclk_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Only 2^9..2^16 map back onto a select code
  always_comb begin
    hit  = 1'b0;
    code = 3'd0;
    for (int k = 9; k <= 16; k++) begin
      if (plen == (CNT_ONE << k)) begin
        hit  = 1'b1;
        code = 3'(16 - k);
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period_o;
    sel_n    = sel_o;
    mcnt_n   = mcnt;
    valid_n  = 1'b0;
    match_n  = match_o;
    lock_n   = lock_o;
    tmo_n    = timeout_o;
    if (!en_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      mcnt_n  = '0;
      lock_n  = 1'b0;
      tmo_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = WAIT_EDGE;
          cnt_n   = '0;
        end
        WAIT_EDGE, MEASURE: begin
          cnt_n = cnt + CNT_ONE;
          if (rise) begin
            state_n = MEASURE;
            cnt_n   = '0;
            tmo_n   = 1'b0;
            if (state == MEASURE) begin
              period_n = plen;
              valid_n  = 1'b1;
              match_n  = hit;
              if (hit) begin
                sel_n = code;
                // a nonzero count implies sel_o holds the previous match
                if (mcnt == '0 || code != sel_o)
                  mcnt_n = 4'd1;
                else if (mcnt != LOCK_N)
                  mcnt_n = mcnt + 4'd1;
              end else begin
                mcnt_n = '0;
              end
              lock_n = (mcnt_n == LOCK_N);
            end
          end else if (cnt == CNT_LAST) begin
            state_n = WAIT_EDGE;
            cnt_n   = '0;
            tmo_n   = 1'b1;
            lock_n  = 1'b0;
            mcnt_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= '0;
      mcnt      <= '0;
      period_o  <= '0;
      sel_o     <= '0;
      valid_o   <= 1'b0;
      match_o   <= 1'b0;
      lock_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mcnt      <= mcnt_n;
      period_o  <= period_n;
      sel_o     <= sel_n;
      valid_o   <= valid_n;
      match_o   <= match_n;
      lock_o    <= lock_n;
      timeout_o <= tmo_n;
    end
  end

endmodule
